// File: rtl/obi_wb_master.sv
// OBI-to-Wishbone classic master bridge: single outstanding transfer, optional bus timeout.
module obi_wb_master #(
  parameter int unsigned WB_ADDR_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  // OBI slave side
  input  logic                     obi_req_i,
  output logic                     obi_gnt_o,
  input  logic [WB_ADDR_WIDTH-1:0] obi_addr_i,
  input  logic                     obi_we_i,
  input  logic [3:0]               obi_be_i,
  input  logic [31:0]              obi_wdata_i,
  output logic                     obi_rvalid_o,
  output logic [31:0]              obi_rdata_o,
  output logic                     obi_err_o,
  // Wishbone master side
  output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [31:0]              wb_wdata_o,
  input  logic [31:0]              wb_rdata_i,
  output logic                     wb_we_o,
  output logic [3:0]               wb_sel_o,
  output logic                     wb_stb_o,
  output logic                     wb_cyc_o,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                     we_q, we_d;
  logic [3:0]               sel_q, sel_d;
  logic [31:0]              wdata_q, wdata_d;
  logic                     cyc_q, cyc_d;
  logic                     rvalid_q, rvalid_d;
  logic [31:0]              rdata_q, rdata_d;
  logic                     err_q, err_d;

  // Grant only while idle; the bridge never holds more than one transfer.
  assign obi_gnt_o = obi_req_i && (state_q == IDLE);

  // Next-state, request latching, response capture and timeout counting.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    sel_d    = sel_q;
    wdata_d  = wdata_q;
    cyc_d    = 1'b0;
    rvalid_d = 1'b0;
    rdata_d  = 32'h0;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (obi_req_i) begin
          addr_d  = {obi_addr_i[WB_ADDR_WIDTH-1:2], 2'b00};
          we_d    = obi_we_i;
          sel_d   = obi_be_i;
          wdata_d = obi_wdata_i;
          cnt_d   = '0;
          if (obi_we_i && (obi_be_i == 4'b0000)) begin
            // Empty write completes without touching the bus.
            state_d  = RESP;
            rvalid_d = 1'b1;
          end else begin
            state_d = BUS;
            cyc_d   = 1'b1;
          end
        end
      end
      BUS: begin
        cyc_d = 1'b1;
        if (wb_err_i || wb_ack_i) begin
          state_d  = RESP;
          cyc_d    = 1'b0;
          rvalid_d = 1'b1;
          err_d    = wb_err_i;
          // Error wins over a simultaneous ack and returns no data.
          rdata_d  = (we_q || (wb_ack_i && wb_err_i)) ? 32'h0 : wb_rdata_i;
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if ((TIMEOUT_CYCLES != 0) && (cnt_d == CNT_LIMIT)) begin
            state_d  = RESP;
            cyc_d    = 1'b0;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      sel_q    <= 4'h0;
      wdata_q  <= 32'h0;
      cyc_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      wdata_q  <= wdata_d;
      cyc_q    <= cyc_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign wb_addr_o    = addr_q;
  assign wb_wdata_o   = wdata_q;
  assign wb_we_o      = we_q;
  assign wb_sel_o     = sel_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign obi_rvalid_o = rvalid_q;
  assign obi_rdata_o  = rdata_q;
  assign obi_err_o    = err_q;

endmodule

// File: tb/tb_obi_wb_master.sv
// Directed testbench for obi_wb_master with a short timeout (4 cycles).
module tb_obi_wb_master;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        obi_req_i;
  logic        obi_gnt_o;
  logic [31:0] obi_addr_i;
  logic        obi_we_i;
  logic [3:0]  obi_be_i;
  logic [31:0] obi_wdata_i;
  logic        obi_rvalid_o;
  logic [31:0] obi_rdata_o;
  logic        obi_err_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_wdata_o;
  logic [31:0] wb_rdata_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;
  logic        wb_err_i;

  int n_assert = 0;
  int n_fail   = 0;

  obi_wb_master #(
    .WB_ADDR_WIDTH (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .obi_req_i   (obi_req_i),
    .obi_gnt_o   (obi_gnt_o),
    .obi_addr_i  (obi_addr_i),
    .obi_we_i    (obi_we_i),
    .obi_be_i    (obi_be_i),
    .obi_wdata_i (obi_wdata_i),
    .obi_rvalid_o(obi_rvalid_o),
    .obi_rdata_o (obi_rdata_o),
    .obi_err_o   (obi_err_o),
    .wb_addr_o   (wb_addr_o),
    .wb_wdata_o  (wb_wdata_o),
    .wb_rdata_i  (wb_rdata_i),
    .wb_we_o     (wb_we_o),
    .wb_sel_o    (wb_sel_o),
    .wb_stb_o    (wb_stb_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_ack_i    (wb_ack_i),
    .wb_err_i    (wb_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Let combinational outputs settle after input changes.
  task automatic settle();
    #2;
  endtask

  initial begin
    rst_i = 1'b1;
    obi_req_i = 1'b0; obi_addr_i = 32'h0; obi_we_i = 1'b0; obi_be_i = 4'h0;
    obi_wdata_i = 32'h0; wb_rdata_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    #3;
    chk("rst_cyc", 32'(wb_cyc_o), 32'h0);
    chk("rst_stb", 32'(wb_stb_o), 32'h0);
    chk("rst_we", 32'(wb_we_o), 32'h0);
    chk("rst_sel", 32'(wb_sel_o), 32'h0);
    chk("rst_addr", wb_addr_o, 32'h0);
    chk("rst_wdata", wb_wdata_o, 32'h0);
    chk("rst_rvalid", 32'(obi_rvalid_o), 32'h0);
    chk("rst_err", 32'(obi_err_o), 32'h0);
    chk("rst_rdata", obi_rdata_o, 32'h0);
    step(); step();
    rst_i = 1'b0;
    step();

    // Read, ack after three bus cycles.
    obi_req_i = 1'b1; obi_addr_i = 32'h0010_0006; obi_we_i = 1'b0; obi_be_i = 4'hF;
    settle();
    chk("rd_gnt0", 32'(obi_gnt_o), 32'h1);
    chk("rd_cyc0", 32'(wb_cyc_o), 32'h0);
    step(); obi_req_i = 1'b0; settle();
    chk("rd_cyc1", 32'(wb_cyc_o), 32'h1);
    chk("rd_stb1", 32'(wb_stb_o), 32'h1);
    chk("rd_addr1", wb_addr_o, 32'h0010_0004);
    chk("rd_we1", 32'(wb_we_o), 32'h0);
    chk("rd_sel1", 32'(wb_sel_o), 32'hF);
    step(); settle();
    chk("rd_cyc2", 32'(wb_cyc_o), 32'h1);
    step(); wb_ack_i = 1'b1; wb_rdata_i = 32'hDEAD_BEEF; settle();
    chk("rd_cyc3", 32'(wb_cyc_o), 32'h1);
    chk("rd_rvalid3", 32'(obi_rvalid_o), 32'h0);
    step(); wb_ack_i = 1'b0; wb_rdata_i = 32'h0; obi_req_i = 1'b1; settle();
    chk("rd_rvalid4", 32'(obi_rvalid_o), 32'h1);
    chk("rd_rdata4", obi_rdata_o, 32'hDEAD_BEEF);
    chk("rd_err4", 32'(obi_err_o), 32'h0);
    chk("rd_cyc4", 32'(wb_cyc_o), 32'h0);
    chk("rd_nogntresp", 32'(obi_gnt_o), 32'h0);
    obi_req_i = 1'b0;
    step(); settle();
    chk("rd_rvalid5", 32'(obi_rvalid_o), 32'h0);
    chk("rd_rdata5", obi_rdata_o, 32'h0);

    // Write, ack in first bus cycle.
    obi_req_i = 1'b1; obi_we_i = 1'b1; obi_be_i = 4'b0011;
    obi_addr_i = 32'h0000_0020; obi_wdata_i = 32'h1234_5678;
    settle();
    chk("wr_gnt0", 32'(obi_gnt_o), 32'h1);
    step(); obi_req_i = 1'b0; wb_ack_i = 1'b1; wb_rdata_i = 32'hFFFF_FFFF; settle();
    chk("wr_cyc1", 32'(wb_cyc_o), 32'h1);
    chk("wr_we1", 32'(wb_we_o), 32'h1);
    chk("wr_sel1", 32'(wb_sel_o), 32'h3);
    chk("wr_wdata1", wb_wdata_o, 32'h1234_5678);
    chk("wr_addr1", wb_addr_o, 32'h0000_0020);
    step(); wb_ack_i = 1'b0; wb_rdata_i = 32'h0; settle();
    chk("wr_rvalid2", 32'(obi_rvalid_o), 32'h1);
    chk("wr_rdata2", obi_rdata_o, 32'h0);
    chk("wr_cyc2", 32'(wb_cyc_o), 32'h0);
    step();

    // Stray ack/err while idle must be ignored.
    wb_ack_i = 1'b1; wb_err_i = 1'b1;
    step(); wb_ack_i = 1'b0; wb_err_i = 1'b0; settle();
    chk("stray_rvalid", 32'(obi_rvalid_o), 32'h0);
    chk("stray_cyc", 32'(wb_cyc_o), 32'h0);

    // Timeout: silent slave, cyc high exactly four cycles.
    obi_req_i = 1'b1; obi_we_i = 1'b0; obi_be_i = 4'hF; obi_addr_i = 32'h0000_0100;
    wb_rdata_i = 32'hCAFE_F00D;
    settle();
    chk("to_gnt0", 32'(obi_gnt_o), 32'h1);
    step(); obi_req_i = 1'b0; settle();
    chk("to_cyc1", 32'(wb_cyc_o), 32'h1);
    step(); settle();
    chk("to_cyc2", 32'(wb_cyc_o), 32'h1);
    step(); settle();
    chk("to_cyc3", 32'(wb_cyc_o), 32'h1);
    step(); settle();
    chk("to_cyc4", 32'(wb_cyc_o), 32'h1);
    chk("to_rvalid4", 32'(obi_rvalid_o), 32'h0);
    step(); settle();
    chk("to_cyc5", 32'(wb_cyc_o), 32'h0);
    chk("to_stb5", 32'(wb_stb_o), 32'h0);
    chk("to_rvalid5", 32'(obi_rvalid_o), 32'h1);
    chk("to_err5", 32'(obi_err_o), 32'h1);
    chk("to_rdata5", obi_rdata_o, 32'h0);
    step(); settle();
    chk("to_rvalid6", 32'(obi_rvalid_o), 32'h0);
    chk("to_err6", 32'(obi_err_o), 32'h0);

    // Simultaneous ack and err on a read: error wins, no data.
    obi_req_i = 1'b1; obi_addr_i = 32'h0000_0200;
    step(); obi_req_i = 1'b0; wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_rdata_i = 32'hAAAA_5555;
    settle();
    chk("ae_cyc1", 32'(wb_cyc_o), 32'h1);
    step(); wb_ack_i = 1'b0; wb_err_i = 1'b0; settle();
    chk("ae_rvalid", 32'(obi_rvalid_o), 32'h1);
    chk("ae_err", 32'(obi_err_o), 32'h1);
    chk("ae_rdata", obi_rdata_o, 32'h0);
    step();

    // Back-to-back with req held: empty write, then a read.
    obi_req_i = 1'b1; obi_we_i = 1'b1; obi_be_i = 4'h0; obi_addr_i = 32'h0000_0300;
    settle();
    chk("bb_gnt0", 32'(obi_gnt_o), 32'h1);
    step(); settle();
    chk("bb_gnt1", 32'(obi_gnt_o), 32'h0);
    chk("bb_cyc1", 32'(wb_cyc_o), 32'h0);
    chk("bb_rvalid1", 32'(obi_rvalid_o), 32'h1);
    chk("bb_err1", 32'(obi_err_o), 32'h0);
    chk("bb_rdata1", obi_rdata_o, 32'h0);
    step(); obi_we_i = 1'b0; obi_be_i = 4'hF; obi_addr_i = 32'h0000_0040; settle();
    chk("bb_gnt2", 32'(obi_gnt_o), 32'h1);
    chk("bb_cyc2", 32'(wb_cyc_o), 32'h0);
    step(); wb_ack_i = 1'b1; wb_rdata_i = 32'h0BAD_F00D; settle();
    chk("bb_gnt3", 32'(obi_gnt_o), 32'h0);
    chk("bb_cyc3", 32'(wb_cyc_o), 32'h1);
    chk("bb_addr3", wb_addr_o, 32'h0000_0040);
    step(); wb_ack_i = 1'b0; settle();
    chk("bb_gnt4", 32'(obi_gnt_o), 32'h0);
    chk("bb_rvalid4", 32'(obi_rvalid_o), 32'h1);
    chk("bb_rdata4", obi_rdata_o, 32'h0BAD_F00D);
    obi_req_i = 1'b0;
    step(); settle();
    chk("bb_gnt5", 32'(obi_gnt_o), 32'h0);
    chk("bb_cyc5", 32'(wb_cyc_o), 32'h0);

    // Reset in the second bus cycle aborts the transfer.
    obi_req_i = 1'b1; obi_we_i = 1'b0; obi_addr_i = 32'h0000_0500;
    step(); obi_req_i = 1'b0; settle();
    chk("rs_cyc1", 32'(wb_cyc_o), 32'h1);
    step(); rst_i = 1'b1; settle();
    chk("rs_cyc2", 32'(wb_cyc_o), 32'h0);
    chk("rs_stb2", 32'(wb_stb_o), 32'h0);
    chk("rs_addr2", wb_addr_o, 32'h0);
    step(); rst_i = 1'b0; wb_ack_i = 1'b1; wb_rdata_i = 32'h1111_2222; settle();
    chk("rs_rvalid3", 32'(obi_rvalid_o), 32'h0);
    step(); wb_ack_i = 1'b0; settle();
    chk("rs_rvalid4", 32'(obi_rvalid_o), 32'h0);
    chk("rs_cyc4", 32'(wb_cyc_o), 32'h0);
    obi_req_i = 1'b1; obi_addr_i = 32'h0000_0604; settle();
    chk("rs_gnt4", 32'(obi_gnt_o), 32'h1);
    step(); obi_req_i = 1'b0; wb_ack_i = 1'b1; wb_rdata_i = 32'h3333_4444; settle();
    chk("rs_cyc5", 32'(wb_cyc_o), 32'h1);
    chk("rs_addr5", wb_addr_o, 32'h0000_0604);
    step(); wb_ack_i = 1'b0; settle();
    chk("rs_rvalid6", 32'(obi_rvalid_o), 32'h1);
    chk("rs_rdata6", obi_rdata_o, 32'h3333_4444);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
